// File: rtl/dir_window_scan_if.sv
// Output stream from the window scanner to the descriptor accumulator.
// One beat per window sample; the beat holds until the consumer accepts it.
interface dir_window_scan_if #(
  parameter int KP_W = 11
);
  logic            m_valid;
  logic            m_ready;
  logic [KP_W-1:0] m_x;
  logic [KP_W-1:0] m_y;
  logic [7:0]      m_idx;
  logic            m_inside;

  modport master (
    output m_valid,
    output m_x,
    output m_y,
    output m_idx,
    output m_inside,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_x,
    input  m_y,
    input  m_idx,
    input  m_inside,
    output m_ready
  );
endinterface

// File: rtl/dir_window_scan.sv
// Walks the 16x16 sample window around a keypoint, reads the x/y direction
// ROMs for each window index, and streams rotated sample coordinates with an
// inside-window flag to the descriptor accumulator.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; rom_addr holds its last value
// SCAN  | addressing the ROMs with cnt and loading the output register
// LAST  | index 255 is in the output register; waiting for its acceptance,
//       | then one more cycle here while done is high
module dir_window_scan #(
  parameter int KP_W   = 11,
  parameter int ROM_DW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KP_W-1:0]   kp_x,
  input  logic [KP_W-1:0]   kp_y,
  output logic              busy,
  output logic [7:0]        rom_addr,
  input  logic [ROM_DW-1:0] rom_dx,
  input  logic [ROM_DW-1:0] rom_dy,
  output logic              done,
  dir_window_scan_if.master m
);

  localparam int EXT_W = KP_W - ROM_DW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    LAST = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [7:0]      cnt_q;
  logic [KP_W-1:0] kpx_q;
  logic [KP_W-1:0] kpy_q;
  logic            accept_start;
  logic            load;
  logic            done_d;

  logic [KP_W-1:0] sum_x;
  logic [KP_W-1:0] sum_y;
  logic            in_dx;
  logic            in_dy;

  // Counter doubles as the ROM address; it stops at 255 so LAST and the
  // following IDLE keep presenting the last driven address.
  assign rom_addr = cnt_q;

  // Offsets are two's complement; the sum wraps modulo 2^KP_W.
  assign sum_x = kpx_q + {{EXT_W{rom_dx[ROM_DW-1]}}, rom_dx};
  assign sum_y = kpy_q + {{EXT_W{rom_dy[ROM_DW-1]}}, rom_dy};

  // An offset lies in [-8, 7] exactly when it fits a 4-bit signed value,
  // i.e. all bits from bit 3 upward agree.
  assign in_dx = (&rom_dx[ROM_DW-1:3]) || (~|rom_dx[ROM_DW-1:3]);
  assign in_dy = (&rom_dy[ROM_DW-1:3]) || (~|rom_dy[ROM_DW-1:3]);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control decode.
  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    load         = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept_start = 1'b1;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (!m.m_valid || m.m_ready) begin
          load = 1'b1;
          if (cnt_q == 8'hff) begin
            state_d = LAST;
          end
        end
      end
      LAST: begin
        // Staying here through the done cycle keeps a coincident start ignored.
        if (done) begin
          state_d = IDLE;
        end else if (m.m_valid && m.m_ready) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Scan counter, latched keypoint, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      kpx_q <= '0;
      kpy_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= done_d;
      if (accept_start) begin
        cnt_q <= 8'd0;
        kpx_q <= kp_x;
        kpy_q <= kp_y;
        busy  <= 1'b1;
      end else begin
        if (load && (cnt_q != 8'hff)) begin
          cnt_q <= cnt_q + 8'd1;
        end
        if (done_d) begin
          busy <= 1'b0;
        end
      end
    end
  end

  // Output register: loads a new beat, otherwise holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m.m_valid  <= 1'b0;
      m.m_x      <= '0;
      m.m_y      <= '0;
      m.m_idx    <= 8'd0;
      m.m_inside <= 1'b0;
    end else if (load) begin
      m.m_valid  <= 1'b1;
      m.m_x      <= sum_x;
      m.m_y      <= sum_y;
      m.m_idx    <= cnt_q;
      m.m_inside <= in_dx && in_dy;
    end else if (m.m_ready) begin
      m.m_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dir_window_scan.sv
// Directed bench for dir_window_scan: ROM model, per-beat checks against a
// small reference model, cycle-accurate timing checks and corner scenarios.
module tb_dir_window_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [10:0] kp_x = 11'd0;
  logic [10:0] kp_y = 11'd0;
  logic        busy;
  logic        done;
  logic [7:0]  rom_addr;
  logic [4:0]  rom_dx;
  logic [4:0]  rom_dy;

  bit          rom_mode = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          first_valid;
  int          last_cyc;
  int          done_cyc;
  logic [30:0] beat0;
  logic [30:0] beat15;
  logic [30:0] beat255;

  dir_window_scan_if #(.KP_W(11)) mif ();

  dir_window_scan #(.KP_W(11), .ROM_DW(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kp_x     (kp_x),
    .kp_y     (kp_y),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_dx   (rom_dx),
    .rom_dy   (rom_dy),
    .done     (done),
    .m        (mif)
  );

  always #5 clk = ~clk;

  // Combinational direction ROM model.
  always_comb begin
    if (rom_mode) rom_dx = (rom_addr == 8'd15) ? 5'h09 : 5'h1f;
    else          rom_dx = {1'b0, rom_addr[3:0]} - 5'd8;
    rom_dy = {1'b0, rom_addr[7:4]} - 5'd8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat {idx, x, y, inside} for a window index.
  function automatic logic [30:0] exp_beat(input logic [7:0] idx, input logic [10:0] kx,
                                           input logic [10:0] ky, input bit mode);
    int dx, dy;
    logic [10:0] ex, ey;
    logic ins;
    if (mode) dx = (idx == 8'd15) ? 9 : -1;
    else      dx = int'(idx[3:0]) - 8;
    dy  = int'(idx[7:4]) - 8;
    ex  = 11'((int'(kx) + dx) & 2047);
    ey  = 11'((int'(ky) + dy) & 2047);
    ins = (dx >= -8) && (dx <= 7) && (dy >= -8) && (dy <= 7);
    return {idx, ex, ey, ins};
  endfunction

  // Pulses start for one edge (edge T), then checks the T+1 state.
  task automatic go(input logic [10:0] kx, input logic [10:0] ky);
    start = 1'b1;
    kp_x  = kx;
    kp_y  = ky;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_T+1", busy, 1);
    chk("rom_addr_T+1", rom_addr, 0);
    chk("m_valid_T+1", mif.m_valid, 0);
  endtask

  // Consumes one scan from cycle T+1 until done. Optionally pulses start
  // with a different keypoint at cycle start_cyc (relative to T).
  task automatic run_scan(input bit rnd, input logic [10:0] kx, input logic [10:0] ky,
                          input int start_cyc, input logic [10:0] nkx, input logic [10:0] nky);
    int cyc = 1;
    int exp_idx = 0;
    int ndone = 0;
    bit stalled = 1'b0;
    logic [7:0] held_addr = 8'd0;
    logic [30:0] obs;
    first_valid = -1;
    last_cyc = -1;
    done_cyc = -1;
    while (cyc < 3000 && ndone == 0) begin
      mif.m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = 1'b0;
      if (cyc == start_cyc) begin
        start = 1'b1;
        kp_x  = nkx;
        kp_y  = nky;
      end
      @(negedge clk);
      if (stalled) chk("addr_frozen", rom_addr, held_addr);
      if (mif.m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        obs = {mif.m_idx, mif.m_x, mif.m_y, mif.m_inside};
        chk("beat", obs, exp_beat(exp_idx[7:0], kx, ky, rom_mode));
        if (exp_idx == 0)   beat0 = obs;
        if (exp_idx == 15)  beat15 = obs;
        if (exp_idx == 255) beat255 = obs;
        stalled   = !mif.m_ready;
        held_addr = rom_addr;
        if (mif.m_ready) begin
          if (exp_idx == 255) last_cyc = cyc;
          exp_idx++;
        end
      end else begin
        stalled = 1'b0;
      end
      chk("busy_level", busy, !done);
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk("beats_at_done", exp_idx, 256);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (ndone == 0) chk("scan_timeout", ndone, 1);
  endtask

  // After a scan: no further done, no stray beats, not busy.
  task automatic post_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_valid", mif.m_valid, 0);
      chk("idle_busy", busy, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    mif.m_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_m_valid", mif.m_valid, 0);
    chk("rst_m_regs", {mif.m_idx, mif.m_x, mif.m_y, mif.m_inside}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: basic scan, m_ready held high.
    go(11'd100, 11'd200);
    run_scan(1'b0, 11'd100, 11'd200, -1, 11'd0, 11'd0);
    chk("s1_first_valid", first_valid, 2);
    chk("s1_last_beat", last_cyc, 257);
    chk("s1_done_cyc", done_cyc, 258);
    chk("s1_idx0", beat0, {8'd0, 11'd92, 11'd192, 1'b1});
    chk("s1_idx255", beat255, {8'd255, 11'd107, 11'd207, 1'b1});
    chk("s1_rom_addr_hold", rom_addr, 255);
    post_idle();

    // Scenario 2: random backpressure.
    go(11'd1000, 11'd3);
    run_scan(1'b1, 11'd1000, 11'd3, -1, 11'd0, 11'd0);
    post_idle();

    // Scenario 3: out-of-range offset at idx 15, wrap elsewhere.
    rom_mode = 1'b1;
    go(11'd0, 11'd50);
    run_scan(1'b0, 11'd0, 11'd50, -1, 11'd0, 11'd0);
    chk("s3_idx15_x", beat15[22:12], 9);
    chk("s3_idx15_inside", beat15[0], 0);
    chk("s3_idx0_x", beat0[22:12], 2047);
    chk("s3_idx0_inside", beat0[0], 1);
    post_idle();
    rom_mode = 1'b0;

    // Scenario 4: start during a scan (beat 40 is valid at cycle 42).
    go(11'd700, 11'd800);
    run_scan(1'b0, 11'd700, 11'd800, 42, 11'd500, 11'd600);
    chk("s4_done_cyc", done_cyc, 258);
    post_idle();

    // Scenario 5: asynchronous reset mid-scan.
    go(11'd300, 11'd400);
    mif.m_ready = 1'b1;
    begin
      int n = 0;
      while (n < 400 && !(mif.m_valid && mif.m_idx == 8'd100)) begin
        @(negedge clk);
        n++;
      end
      chk("s5_reach_idx100", mif.m_idx, 100);
    end
    #1 rst_n = 1'b0;
    #1;
    chk("s5_valid_low", mif.m_valid, 0);
    chk("s5_busy_low", busy, 0);
    chk("s5_done_low", done, 0);
    chk("s5_rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    go(11'd5, 11'd6);
    run_scan(1'b0, 11'd5, 11'd6, -1, 11'd0, 11'd0);
    chk("s5_restart_first_valid", first_valid, 2);
    post_idle();

    // Scenario 6: start in the done cycle is ignored; one cycle later it starts.
    go(11'd20, 11'd30);
    run_scan(1'b0, 11'd20, 11'd30, 258, 11'd40, 11'd50);
    chk("s6_done_cyc", done_cyc, 258);
    chk("s6_start_on_done_ignored", busy, 0);
    chk("s6_no_beat", mif.m_valid, 0);
    go(11'd40, 11'd50);
    run_scan(1'b0, 11'd40, 11'd50, -1, 11'd0, 11'd0);
    chk("s6_second_first_valid", first_valid, 2);
    chk("s6_second_idx0", beat0, {8'd0, 11'd32, 11'd42, 1'b1});
    post_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
